muldiv_ex: RTL

- Iterative multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes operands and the decoded MULT/MULTU/DIV/DIVU operation that the ID/EX pipeline register presents in EX.
- Holds the architectural HI/LO registers.
- Raises `busy` so hazard logic can stall IF/ID/EX while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 38 +++
 rtl/muldiv_signfix.sv | 10 +
 rtl/muldiv_ex.sv | 127 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for the EX-stage mul/div unit
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - operation/result bundle between ID/EX and the mul/div unit; MTHI/MTLO port under MULDIV_MTHILO_EN
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_MTHILO_EN
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
`endif

  modport master (
    output start, op, opa, opb, flush,
`ifdef MULDIV_MTHILO_EN
    output hi_we, lo_we, wr_data,
`endif
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, flush,
`ifdef MULDIV_MTHILO_EN
    input  hi_we, lo_we, wr_data,
`endif
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negate of a value
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);
  assign result = neg ? (~value + W'(1)) : value;
endmodule

// File: rtl/muldiv_ex.sv
// rtl/muldiv_ex.sv - iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; optional MTHI/MTLO via MULDIV_MTHILO_EN
module muldiv_ex
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem, divisor, raw_a, hi_q, lo_q;
  logic               busy_q, done_q, dbz_q;
  logic               res_neg, rem_neg, is_div, b_zero;
  logic               is_signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, shifted, diff;

  assign is_signed_op = ~bus.op[0];

  muldiv_signfix #(.W(WIDTH)) u_amag (.neg(is_signed_op & bus.opa[WIDTH-1]), .value(bus.opa), .result(a_mag));
  muldiv_signfix #(.W(WIDTH)) u_bmag (.neg(is_signed_op & bus.opb[WIDTH-1]), .value(bus.opb), .result(b_mag));
  muldiv_signfix #(.W(2*WIDTH)) u_prod (.neg(res_neg), .value(acc), .result(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_quo (.neg(res_neg), .value(acc[WIDTH-1:0]), .result(quo_fix));
  muldiv_signfix #(.W(WIDTH)) u_rem (.neg(rem_neg), .value(rem), .result(rem_fix));

  // MUL: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
  // DIV: dividend sits in acc low half; quotient bits shift in behind it.
  assign shifted = {rem, acc[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      divisor <= '0;
      raw_a   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_MTHILO_EN
      if (!busy_q && bus.hi_we) hi_q <= bus.wr_data;
      if (!busy_q && bus.lo_we) lo_q <= bus.wr_data;
`endif
      case (state)
        IDLE, DONE: begin
          if (bus.start && !bus.flush) begin
            state   <= bus.op[1] ? DIV : MUL;
            busy_q  <= 1'b1;
            cnt     <= '0;
            dbz_q   <= 1'b0;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            divisor <= bus.op[1] ? b_mag : a_mag;
            rem     <= '0;
            raw_a   <= bus.opa;
            b_zero  <= (bus.opb == '0);
            is_div  <= bus.op[1];
            res_neg <= is_signed_op & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            rem_neg <= is_signed_op & bus.opa[WIDTH-1];
          end else begin
            state <= IDLE;
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (state == MUL) begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end else begin
              rem              <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
              acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~diff[WIDTH]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
            dbz_q  <= is_div & b_zero;
            if (!is_div) begin
              {hi_q, lo_q} <= prod_fix;
            end else if (b_zero) begin
              lo_q <= '1;
              hi_q <= raw_a;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
